pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and target width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0040_0000: first fetch address.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h8000_0180: trap handler address.
REQ-004 SHALL have parameter CNT_W, default 16: width of the taken-redirect counter.
REQ-005 Ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- fetch_ready  in  1  fetch accepts current pc this cycle.
- stall  in  1  hold pc (pipeline hazard).
- exc  in  1  external exception request.
- jmp  in  1  unconditional jump.
- br_op  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 JR.
- is_zero, is_lt, is_ltu  in  1 each  ALU compare flags (A==B, A<B signed, A<B unsigned).
- jmp_target, branch_target, jr_target  in  XLEN each  candidate addresses.
- pc  out  XLEN  fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- redirect  out  1  one-cycle pulse: non-sequential pc load.
- epc  out  XLEN  pc held at last trap.
- cause  out  2  00 none, 01 external exc, 10 misaligned target.
- taken_cnt  out  CNT_W  count of taken redirects.

Function
REQ-006 SHALL implement FSM states BOOT, RUN, TRAP.
REQ-007 BOOT: pc=RESET_VECTOR, pc_valid=0; unconditionally -> RUN next cycle.
REQ-008 RUN: pc_valid=1; TRAP: pc_valid=0 for exactly one cycle, pc=EXC_VECTOR, then -> RUN.
REQ-009 Branch taken: BEQ is_zero; BNE !is_zero; BLT is_lt; BGE !is_lt; BLTU is_ltu; BGEU !is_ltu; JR always.
REQ-010 In RUN, next pc priority: exc > misaligned chosen target > jmp (jmp_target) > taken br_op (branch_target, or jr_target for JR) > sequential.
REQ-011 Sequential: pc <= pc + 4 (mod 2^XLEN) only when fetch_ready=1 and stall=0; otherwise pc holds.
REQ-012 Redirects (jmp, taken branch, exc) SHALL apply regardless of stall and fetch_ready.
REQ-013 A chosen target with bits [1:0] != 0 SHALL not load pc; trap with cause=10.
REQ-014 On trap: epc <= current pc, cause updated, next state TRAP, pc <= EXC_VECTOR; redirect=1.
REQ-015 redirect SHALL pulse high in the cycle after a jmp/taken-branch/trap decision, coincident with new pc.
REQ-016 taken_cnt SHALL increment on each jmp or taken branch (not traps), saturating at all-ones.
REQ-017 Control inputs in BOOT and TRAP SHALL be ignored.
REQ-018 pc wrap at 2^XLEN-4 + 4 SHALL yield 0, no error.

Reset
REQ-019 On rst_n=0 at clk edge: state=BOOT, pc=RESET_VECTOR, pc_valid=0, redirect=0, epc=0, cause=00, taken_cnt=0.
REQ-020 Reset asserted mid-operation SHALL override any simultaneous redirect or exception.

Structure
REQ-021 br_op encodings, cause encodings, FSM state encoding SHALL reside in shared package pc_pkg.
REQ-022 Branch-condition evaluation SHALL be sub-module br_cond (br_op + flags -> taken), combinational.

Verification
REQ-023 Reset release: cycle 0 pc=0x00400000 pc_valid=0; cycle 1 pc_valid=1; 3 ready cycles -> pc=0x0040000C.
REQ-024 BNE with is_zero=0, branch_target=0x00400100, stall=1 -> next pc=0x00400100, redirect=1, taken_cnt=1.
REQ-025 BEQ with is_zero=0 and fetch_ready=0 -> pc unchanged, redirect=0, taken_cnt unchanged.
REQ-026 exc and jmp same cycle at pc=0x00400020 -> epc=0x00400020, cause=01, pc=0x80000180, pc_valid=0 one cycle, taken_cnt unchanged.
REQ-027 JR jr_target=0x00400102 -> trap cause=10, pc not 0x00400102.
REQ-028 CNT_W=2: five taken jumps -> taken_cnt=3.

Source files
------------

// File: rtl/pc_pkg.sv
// +--------------------------------------------------------------------+
// | pc_pkg : shared encodings for the fetch PC sequencer (rev 1.0)     |
// +--------------------------------------------------------------------+
`default_nettype none

package pc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110,
    BR_JR   = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_EXC      = 2'b01,
    CAUSE_MISALIGN = 2'b10
  } cause_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10
  } state_e;

  localparam int c_PC_STEP = 4;

  // Instruction fetch is word-granular: any set low bit is a bad target.
  function automatic logic is_misaligned(input logic [1:0] i_lsbs);
    return (i_lsbs != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/br_cond.sv
// +--------------------------------------------------------------------+
// | br_cond : combinational branch-taken decode from ALU flags (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module br_cond
  import pc_pkg::*;
(
  input  logic [2:0] i_br_op,
  input  logic       i_is_zero,
  input  logic       i_is_lt,
  input  logic       i_is_ltu,
  output logic       o_taken
);

  br_op_e w_op;

  assign w_op = br_op_e'(i_br_op);

  always_comb begin
    o_taken = 1'b0;
    case (w_op)
      BR_NONE: o_taken = 1'b0;
      BR_BEQ:  o_taken = i_is_zero;
      BR_BNE:  o_taken = ~i_is_zero;
      BR_BLT:  o_taken = i_is_lt;
      BR_BGE:  o_taken = ~i_is_lt;
      BR_BLTU: o_taken = i_is_ltu;
      BR_BGEU: o_taken = ~i_is_ltu;
      BR_JR:   o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +--------------------------------------------------------------------+
// | pc_sequencer : fetch PC FSM with jumps, branches and traps (rev 1.0)|
// +--------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             exc,
  input  logic             jmp,
  input  logic [2:0]       br_op,
  input  logic             is_zero,
  input  logic             is_lt,
  input  logic             is_ltu,
  input  logic [XLEN-1:0]  jmp_target,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  jr_target,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic             redirect,
  output logic [XLEN-1:0]  epc,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_pc_valid;
  logic              r_redirect;
  logic [XLEN-1:0]   r_epc;
  cause_e            r_cause;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic              w_br_taken;
  logic              w_have_tgt;
  logic              w_misalign;
  logic              w_seq_adv;
  logic              w_cnt_sat;
  logic [XLEN-1:0]   w_tgt;
  logic [XLEN-1:0]   w_pc_seq;

  br_cond u_br_cond (
    .i_br_op   (br_op),
    .i_is_zero (is_zero),
    .i_is_lt   (is_lt),
    .i_is_ltu  (is_ltu),
    .o_taken   (w_br_taken)
  );

  // jmp outranks a simultaneous branch, so its target is the one vetted.
  always_comb begin
    w_tgt = branch_target;
    if (jmp) begin
      w_tgt = jmp_target;
    end else if (br_op_e'(br_op) == BR_JR) begin
      w_tgt = jr_target;
    end
  end

  assign w_have_tgt = jmp | w_br_taken;
  assign w_misalign = w_have_tgt & is_misaligned(w_tgt[1:0]);
  assign w_seq_adv  = fetch_ready & ~stall;
  assign w_pc_seq   = r_pc + XLEN'(c_PC_STEP);
  assign w_cnt_sat  = &r_taken_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VECTOR;
      r_pc_valid  <= 1'b0;
      r_redirect  <= 1'b0;
      r_epc       <= '0;
      r_cause     <= CAUSE_NONE;
      r_taken_cnt <= '0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_pc       <= RESET_VECTOR;
          r_pc_valid <= 1'b1;
        end
        ST_TRAP: begin
          r_state    <= ST_RUN;
          r_pc       <= EXC_VECTOR;
          r_pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (exc || w_misalign) begin
            r_state    <= ST_TRAP;
            r_epc      <= r_pc;
            r_cause    <= exc ? CAUSE_EXC : CAUSE_MISALIGN;
            r_pc       <= EXC_VECTOR;
            r_pc_valid <= 1'b0;
            r_redirect <= 1'b1;
          end else if (w_have_tgt) begin
            r_pc       <= w_tgt;
            r_redirect <= 1'b1;
            if (!w_cnt_sat) begin
              r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
          end else if (w_seq_adv) begin
            r_pc <= w_pc_seq;
          end
        end
        default: begin
          r_state    <= ST_BOOT;
          r_pc       <= RESET_VECTOR;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = r_pc;
  assign pc_valid  = r_pc_valid;
  assign redirect  = r_redirect;
  assign epc       = r_epc;
  assign cause     = r_cause;
  assign taken_cnt = r_taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_pc_sequencer : scoreboard bench for pc_sequencer (rev 1.0)       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] c_RV  = 32'h0040_0000;
  localparam logic [31:0] c_EXC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst_n, fetch_ready, stall, exc, jmp;
  logic [2:0]  br_op;
  logic        is_zero, is_lt, is_ltu;
  logic [31:0] jmp_target, branch_target, jr_target;

  logic [31:0] pc, epc, pc2, epc2;
  logic        pc_valid, redirect, pc_valid2, redirect2;
  logic [1:0]  cause, cause2;
  logic [15:0] taken_cnt;
  logic [1:0]  taken_cnt2;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall),
    .exc(exc), .jmp(jmp), .br_op(br_op), .is_zero(is_zero), .is_lt(is_lt),
    .is_ltu(is_ltu), .jmp_target(jmp_target), .branch_target(branch_target),
    .jr_target(jr_target), .pc(pc), .pc_valid(pc_valid), .redirect(redirect),
    .epc(epc), .cause(cause), .taken_cnt(taken_cnt)
  );

  pc_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall),
    .exc(exc), .jmp(jmp), .br_op(br_op), .is_zero(is_zero), .is_lt(is_lt),
    .is_ltu(is_ltu), .jmp_target(jmp_target), .branch_target(branch_target),
    .jr_target(jr_target), .pc(pc2), .pc_valid(pc_valid2), .redirect(redirect2),
    .epc(epc2), .cause(cause2), .taken_cnt(taken_cnt2)
  );

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        rd;
    logic [31:0] epc;
    logic [1:0]  cause;
    int          cnt;
  } exp_t;

  exp_t q[$];

  // reference model state (0 boot, 1 run, 2 trap)
  int          m_st;
  logic [31:0] m_pc, m_epc;
  logic        m_v, m_rd;
  logic [1:0]  m_cause;
  int          m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic model_taken(input logic [2:0] op);
    case (op)
      3'b001:  return is_zero;
      3'b010:  return !is_zero;
      3'b011:  return is_lt;
      3'b100:  return !is_lt;
      3'b101:  return is_ltu;
      3'b110:  return !is_ltu;
      3'b111:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_trap(input logic [1:0] c);
    m_epc = m_pc; m_cause = c; m_pc = c_EXC; m_st = 2; m_v = 1'b0; m_rd = 1'b1;
  endtask

  task automatic predict();
    exp_t e;
    logic        tk;
    logic [31:0] tgt;
    if (!rst_n) begin
      m_st = 0; m_pc = c_RV; m_v = 0; m_rd = 0; m_epc = 0; m_cause = 0; m_cnt = 0;
    end else if (m_st != 1) begin
      m_st = 1; m_v = 1'b1; m_rd = 1'b0;
    end else begin
      tk  = jmp || model_taken(br_op);
      tgt = jmp ? jmp_target : ((br_op == 3'b111) ? jr_target : branch_target);
      m_rd = 1'b0;
      if (exc) model_trap(2'b01);
      else if (tk && tgt[1:0] != 2'b00) model_trap(2'b10);
      else if (tk) begin m_pc = tgt; m_rd = 1'b1; m_cnt++; end
      else if (fetch_ready && !stall) m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.v = m_v; e.rd = m_rd; e.epc = m_epc; e.cause = m_cause; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_eq("pc", pc, e.pc);
    check_eq("pc_valid", pc_valid, e.v);
    check_eq("redirect", redirect, e.rd);
    check_eq("epc", epc, e.epc);
    check_eq("cause", cause, e.cause);
    check_eq("taken_cnt", taken_cnt, (e.cnt > 65535) ? 64'd65535 : 64'(e.cnt));
    check_eq("taken_cnt_w2", taken_cnt2, (e.cnt > 3) ? 64'd3 : 64'(e.cnt));
  endtask

  task automatic idle();
    exc = 0; jmp = 0; br_op = 3'b000; stall = 0;
  endtask

  initial begin
    rst_n = 0; fetch_ready = 0; stall = 0; exc = 0; jmp = 0; br_op = 0;
    is_zero = 0; is_lt = 0; is_ltu = 0;
    jmp_target = 0; branch_target = 0; jr_target = 0;
    @(posedge clk); #1;
    exc = 1; jmp = 1; jmp_target = 32'h100;
    cyc(); cyc();
    check_eq("rst_pc", pc, c_RV);
    check_eq("rst_valid", pc_valid, 0);
    check_eq("rst_cnt", taken_cnt, 0);
    idle();

    rst_n = 1;
    cyc();
    check_eq("boot_valid1", pc_valid, 1);
    fetch_ready = 1;
    repeat (3) cyc();
    check_eq("seq_pc", pc, 32'h0040_000C);

    br_op = 3'b010; is_zero = 0; branch_target = 32'h0040_0100; stall = 1;
    cyc();
    check_eq("bne_pc", pc, 32'h0040_0100);
    check_eq("bne_redirect", redirect, 1);
    check_eq("bne_cnt", taken_cnt, 1);
    idle();

    br_op = 3'b001; is_zero = 0; fetch_ready = 0;
    cyc();
    check_eq("beq_nt_pc", pc, 32'h0040_0100);
    check_eq("beq_nt_redirect", redirect, 0);
    check_eq("beq_nt_cnt", taken_cnt, 1);
    idle();

    jmp = 1; jmp_target = 32'h0040_0020;
    cyc();
    exc = 1; jmp = 1; jmp_target = 32'h0040_0040;
    cyc();
    check_eq("exc_epc", epc, 32'h0040_0020);
    check_eq("exc_cause", cause, 2'b01);
    check_eq("exc_pc", pc, c_EXC);
    check_eq("exc_valid", pc_valid, 0);
    check_eq("exc_cnt", taken_cnt, 2);
    // inputs held during the trap cycle must be ignored
    cyc();
    check_eq("trap_exit_valid", pc_valid, 1);
    check_eq("trap_exit_pc", pc, c_EXC);
    idle();

    br_op = 3'b111; jr_target = 32'h0040_0102;
    cyc();
    check_eq("jr_mis_cause", cause, 2'b10);
    check_eq("jr_mis_pc", pc, c_EXC);
    idle();
    cyc();

    jmp = 1; jmp_target = 32'hFFFF_FFF8;
    cyc();
    idle(); fetch_ready = 1;
    cyc(); cyc();
    check_eq("wrap_pc", pc, 32'h0);

    for (int i = 0; i < 5; i++) begin
      jmp = 1; jmp_target = 32'h0040_1000 + 32'(i * 16);
      cyc();
    end
    check_eq("sat_cnt_w2", taken_cnt2, 2'd3);
    idle();

    for (int i = 0; i < 120; i++) begin
      rst_n       = ($urandom_range(0, 39) != 0);
      exc         = ($urandom_range(0, 9) == 0);
      jmp         = ($urandom_range(0, 5) == 0);
      br_op       = 3'($urandom_range(0, 7));
      is_zero     = 1'($urandom_range(0, 1));
      is_lt       = 1'($urandom_range(0, 1));
      is_ltu      = 1'($urandom_range(0, 1));
      fetch_ready = 1'($urandom_range(0, 1));
      stall       = ($urandom_range(0, 3) == 0);
      jmp_target    = $urandom();
      branch_target = $urandom();
      jr_target     = $urandom();
      if ($urandom_range(0, 3) != 0) jmp_target[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
